// File: rtl/bscan_pkg.sv
// Shared boundary-scan instruction encoding for the chain and its users.
package bscan_pkg;

   typedef enum logic [2:0] {
      BS_NORMAL = 3'd0,
      BS_SAMPLE = 3'd1,
      BS_EXTEST = 3'd2,
      BS_INTEST = 3'd3,
      BS_CLAMP  = 3'd4,
      BS_HIGHZ  = 3'd5
   } bscan_instr_t;

endpackage

// File: rtl/bscan_sync_cell.sv
// One boundary-scan cell: a capture/shift flop feeding an update flop.
// The two enables are mutually exclusive; arbitration is done in the chain top.
module bscan_sync_cell (
   input  logic clk_i,
   input  logic rst_i,
   input  logic cap_en_i,
   input  logic shift_en_i,
   input  logic upd_en_i,
   input  logic cap_d_i,
   input  logic si_i,
   output logic so_o,
   output logic upd_o
);

   logic sr_q, sr_d;
   logic upd_q, upd_d;

   always_comb begin
      sr_d  = sr_q;
      upd_d = upd_q;
      if (cap_en_i)        sr_d = cap_d_i;
      else if (shift_en_i) sr_d = si_i;
      if (upd_en_i)        upd_d = sr_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q  <= 1'b0;
         upd_q <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         upd_q <= upd_d;
      end
   end

   assign so_o  = sr_q;
   assign upd_o = upd_q;

endmodule

// File: rtl/bscan_chain.sv
// Boundary-scan register chain for input pins, output pins and grouped OE control cells.
// Bit 0 (input cells) is nearest tdo; control cells sit nearest tdi.
module bscan_chain
   import bscan_pkg::*;
#(
   parameter int NUM_IN   = 8,
   parameter int NUM_OUT  = 8,
   parameter int OE_GROUP = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         select,
   input  logic                         capture_dr,
   input  logic                         shift_dr,
   input  logic                         update_dr,
   input  bscan_instr_t                 instr,
   input  logic                         tdi,
   output logic                         tdo,
   input  logic [NUM_IN-1:0]            pin_in,
   output logic [NUM_IN-1:0]            core_in,
   input  logic [NUM_OUT-1:0]           core_out,
   input  logic [NUM_OUT/OE_GROUP-1:0]  core_oe,
   output logic [NUM_OUT-1:0]           pin_out,
   output logic [NUM_OUT-1:0]           pin_oe
);

   localparam int NUM_OE = NUM_OUT / OE_GROUP;
   localparam int L      = NUM_IN + NUM_OUT + NUM_OE;

   if ((NUM_OUT % OE_GROUP) != 0) begin : g_bad_group
      $error("bscan_chain: NUM_OUT must be a multiple of OE_GROUP");
   end

   logic [L-1:0]       cap_vec, si_vec, sr, upd;
   logic [NUM_IN-1:0]  upd_in;
   logic [NUM_OUT-1:0] upd_out, upd_oe_x, core_oe_x;
   logic [NUM_OE-1:0]  upd_ctl;
   logic               cap_en, shift_en, upd_en;

   // Capture beats shift beats update; only the winner acts.
   assign cap_en   = select & capture_dr;
   assign shift_en = select & shift_dr & ~capture_dr;
   assign upd_en   = select & update_dr & ~capture_dr & ~shift_dr;

   assign cap_vec = {core_oe, core_out, pin_in};
   assign si_vec  = {tdi, sr[L-1:1]};
   assign tdo     = sr[0];

   for (genvar i = 0; i < L; i++) begin : g_cell
      bscan_sync_cell u_cell (
         .clk_i      (clk),
         .rst_i      (rst),
         .cap_en_i   (cap_en),
         .shift_en_i (shift_en),
         .upd_en_i   (upd_en),
         .cap_d_i    (cap_vec[i]),
         .si_i       (si_vec[i]),
         .so_o       (sr[i]),
         .upd_o      (upd[i])
      );
   end

   assign upd_in  = upd[NUM_IN-1:0];
   assign upd_out = upd[NUM_IN +: NUM_OUT];
   assign upd_ctl = upd[NUM_IN+NUM_OUT +: NUM_OE];

   for (genvar g = 0; g < NUM_OE; g++) begin : g_oe
      assign core_oe_x[g*OE_GROUP +: OE_GROUP] = {OE_GROUP{core_oe[g]}};
      assign upd_oe_x[g*OE_GROUP +: OE_GROUP]  = {OE_GROUP{upd_ctl[g]}};
   end

   always_comb begin
      pin_out = core_out;
      pin_oe  = core_oe_x;
      core_in = pin_in;
      case (instr)
         BS_EXTEST, BS_CLAMP: begin
            pin_out = upd_out;
            pin_oe  = upd_oe_x;
         end
         BS_INTEST: begin
            pin_out = upd_out;
            pin_oe  = upd_oe_x;
            core_in = upd_in;
         end
         BS_HIGHZ: begin
            pin_out = upd_out;
            pin_oe  = '0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bscan_chain.sv
// Directed bench for bscan_chain with NUM_IN=4, NUM_OUT=4, OE_GROUP=2 (L=10).
module tb_bscan_chain;
   import bscan_pkg::*;

   logic         clk = 1'b0;
   logic         rst, select, capture_dr, shift_dr, update_dr, tdi, tdo;
   bscan_instr_t instr;
   logic [3:0]   pin_in, core_in, core_out, pin_out, pin_oe;
   logic [1:0]   core_oe;

   int passed = 0;
   int total  = 0;

   bscan_chain #(.NUM_IN(4), .NUM_OUT(4), .OE_GROUP(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .select     (select),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .instr      (instr),
      .tdi        (tdi),
      .tdo        (tdo),
      .pin_in     (pin_in),
      .core_in    (core_in),
      .core_out   (core_out),
      .core_oe    (core_oe),
      .pin_out    (pin_out),
      .pin_oe     (pin_oe)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Shift a 10-bit vector in LSB first, then pulse update.
   task automatic load(input logic [9:0] v);
      shift_dr = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tdi = v[i];
         tick();
      end
      shift_dr  = 1'b0;
      update_dr = 1'b1;
      tick();
      update_dr = 1'b0;
      tdi = 1'b0;
   endtask

   logic [9:0] stream;

   initial begin
      rst = 1'b1; select = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
      tdi = 1'b0; instr = BS_NORMAL; pin_in = 4'h0; core_out = 4'h0; core_oe = 2'b00;
      tick(); tick();

      // Reset in the middle of a shift of ones
      rst = 1'b0; select = 1'b1; shift_dr = 1'b1; tdi = 1'b1;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; shift_dr = 1'b0; tdi = 1'b0;
      chk("rst_tdo", 16'(tdo), 16'h0);
      instr = BS_EXTEST;
      #1;
      chk("rst_extest_oe", 16'(pin_oe), 16'h0);
      chk("rst_extest_out", 16'(pin_out), 16'h0);

      // NORMAL and undefined code pass through
      pin_in = 4'hA; core_out = 4'h5; core_oe = 2'b10;
      instr = BS_NORMAL;
      #1;
      chk("normal_out", 16'(pin_out), 16'h5);
      chk("normal_oe", 16'(pin_oe), 16'hC);
      chk("normal_core_in", 16'(core_in), 16'hA);
      instr = bscan_instr_t'(3'd7);
      #1;
      chk("code7_out", 16'(pin_out), 16'h5);
      chk("code7_oe", 16'(pin_oe), 16'hC);
      chk("code7_core_in", 16'(core_in), 16'hA);
      instr = BS_SAMPLE;

      // Capture and shift out: {ctl=10, out=0101, in=1010}
      capture_dr = 1'b1;
      tick();
      capture_dr = 1'b0;
      stream = 10'b10_0101_1010;
      shift_dr = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("sample_tdo%0d", i), 16'(tdo), 16'(stream[i]));
         tick();
      end
      shift_dr = 1'b0;

      // Preload then EXTEST / HIGHZ / CLAMP
      load(10'b11_0011_0110);
      instr = BS_EXTEST;
      #1;
      chk("extest_out", 16'(pin_out), 16'h3);
      chk("extest_oe", 16'(pin_oe), 16'hF);
      chk("extest_core_in", 16'(core_in), 16'hA);
      instr = BS_HIGHZ;
      #1;
      chk("highz_oe", 16'(pin_oe), 16'h0);
      chk("highz_out", 16'(pin_out), 16'h3);
      chk("highz_core_in", 16'(core_in), 16'hA);
      instr = BS_CLAMP;
      #1;
      chk("clamp_oe", 16'(pin_oe), 16'hF);
      chk("clamp_core_in", 16'(core_in), 16'hA);

      // INTEST: {ctl=01, out=1100, in=1001}
      load(10'b01_1100_1001);
      instr = BS_INTEST;
      #1;
      chk("intest_core_in", 16'(core_in), 16'h9);
      chk("intest_oe", 16'(pin_oe), 16'h3);
      pin_in = 4'h6;
      #1;
      chk("intest_core_in_pin6", 16'(core_in), 16'h9);
      capture_dr = 1'b1;
      tick();
      capture_dr = 1'b0;
      shift_dr = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("intest_stable%0d", i), 16'(pin_out), 16'hC);
         tick();
      end
      shift_dr = 1'b0;
      chk("intest_after_shift", 16'(pin_out), 16'hC);

      // sr is all zero now; deselected strobes must do nothing
      pin_in = 4'h7;
      select = 1'b0; capture_dr = 1'b1; shift_dr = 1'b1; update_dr = 1'b1; tdi = 1'b1;
      tick();
      chk("desel_tdo", 16'(tdo), 16'h0);
      chk("desel_upd", 16'(pin_out), 16'hC);

      // All strobes with select: capture alone wins
      select = 1'b1;
      tick();
      capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; tdi = 1'b0;
      chk("prio_upd", 16'(pin_out), 16'hC);
      stream = 10'b10_0101_0111;
      shift_dr = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("prio_tdo%0d", i), 16'(tdo), 16'(stream[i]));
         tick();
      end
      shift_dr = 1'b0;
      chk("no_wrap_tdo", 16'(tdo), 16'h0);

      // Mid-EXTEST reset drops the enables
      load(10'b11_0011_0110);
      instr = BS_EXTEST;
      #1;
      chk("pre_rst_oe", 16'(pin_oe), 16'hF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_oe", 16'(pin_oe), 16'h0);
      chk("midrst_out", 16'(pin_out), 16'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/bscan_chain.md
# bscan_chain

Parametrised, single-clock boundary-scan register chain for input pins and tristate output pins, with grouped output-enable control cells. Capture, shift and update are clock-enable strobes from the TAP controller rather than gated clocks. Instruction-driven muxing supports NORMAL, SAMPLE/PRELOAD, EXTEST, INTEST, CLAMP and HIGHZ. The block sits between the core and the pad ring; its serial path is selected by the TAP's IR decode.

## Interface
- NUM_IN, default 8: number of input-pin cells (≥1).
- NUM_OUT, default 8: number of output-pin cells (≥1).
- OE_GROUP, default 4: outputs sharing one control cell. NUM_OUT % OE_GROUP must be 0; elaboration fails otherwise.
- Derived: NUM_OE = NUM_OUT/OE_GROUP; L = NUM_IN + NUM_OUT + NUM_OE.

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset, synchronous and active-high.
- select  in  1  this register is the IR-selected data register.
- capture_dr / shift_dr / update_dr  in  1 each  one-cycle strobes from the TAP.
- instr  in  bscan_instr_t  current decoded instruction.
- tdi  in  1  serial in.
- tdo  out  1  serial out, = sr[0].
- pin_in  in  NUM_IN  from pads.
- core_in  out  NUM_IN  to core.
- core_out  in  NUM_OUT  from core.
- core_oe  in  NUM_OE  from core, bit g enables outputs g*OE_GROUP .. g*OE_GROUP+OE_GROUP-1.
- pin_out  out  NUM_OUT  to pads.
- pin_oe  out  NUM_OUT  to pads, expanded per group.

## Operation
- State: shift register sr[L-1:0] and update register upd[L-1:0].
- Bit map, tdo side first: sr[NUM_IN-1:0] are input cells; the next NUM_OUT bits are output cells; the top NUM_OE bits are control cells, nearest tdi.
- Capture (select & capture_dr): input cells take pin_in, output cells take core_out, control cells take core_oe. Capture is identical for every instruction.
- Shift (select & shift_dr): sr <= {tdi, sr[L-1:1]}.
- Update (select & update_dr): upd <= sr.
- Strobe priority when several are high in one cycle: capture > shift > update. Only the winner acts.
- select=0: all strobes are ignored; sr and upd hold.
- Output mux, combinational from instr and upd:
  - NORMAL, SAMPLE, or any undefined code: pin_out=core_out, pin_oe=expand(core_oe), core_in=pin_in.
  - EXTEST: pin_out=upd_out, pin_oe=expand(upd_ctl), core_in=pin_in.
  - INTEST: pins as EXTEST; core_in=upd_in.
  - CLAMP: pins as EXTEST; core_in=pin_in.
  - HIGHZ: pin_oe=0, pin_out=upd_out, core_in=pin_in.

## Timing
- Reset: sr=0, upd=0, so tdo=0. In test modes this means pin_oe=0 (safe).
- Reset has priority over all strobes, including mid-shift. Shift then restarts from all-zero.
- Strobes act at the clk edge where they are sampled high. sr/upd are visible the following cycle.
- tdo changes only after a capture or shift edge; it is never combinational from tdi.
- upd changes only on update. Pin outputs in test modes are glitch-free across shift and capture.
- instr changes take effect combinationally in the same cycle. No internal mode register.
- An L-bit load needs exactly L shift strobes. Extra shifts keep moving data out of tdo (no wrap).

## Structure
- Package bscan_pkg holds typedef enum logic [2:0] bscan_instr_t: BS_NORMAL=0, BS_SAMPLE=1, BS_EXTEST=2, BS_INTEST=3, BS_CLAMP=4, BS_HIGHZ=5. Codes 6 and 7 decode as NORMAL.
- Sub-module bscan_sync_cell: one capture/shift flop plus one update flop with enables and sync reset. It is instantiated L times, and control cells reuse it.
- The OE expansion and the mux are generate logic in the top.

## Test plan
(NUM_IN=4, NUM_OUT=4, OE_GROUP=2, L=10.)
- Reset: assert rst during a shift, release -> tdo=0, upd=0, and in EXTEST pin_oe=4'b0000.
- Sample: pin_in=4'hA, core_out=4'h5, core_oe=2'b10, capture, then 10 shifts -> tdo stream LSB-first is 0,1,0,1, 1,0,1,0, 0,1.
- Preload/EXTEST: shift 10'b11_0011_0110, update, instr=EXTEST -> pin_out=4'h3, pin_oe=4'hF, core_in=pin_in. Then switch to HIGHZ -> pin_oe=0.
- INTEST: load upd_in=4'h9, instr=INTEST -> core_in=4'h9 regardless of pin_in. During a further capture and 10 shifts, pin_out stays stable.
- Gating and priority: select=0 with all strobes high -> sr/upd unchanged. select=1 with capture and shift both high -> capture result only.
- Modes: instr=3'd7 behaves as NORMAL. Mid-EXTEST reset forces pin_oe=0 on the next cycle.
